dijkstra_min_tracker: RTL and testbench

Multi-cycle Nios II custom-instruction block that sits directly downstream of the relaxation step: software feeds it each relaxed candidate (node index, IEEE-754 single distance) and it keeps a running minimum over the current frontier. Software later reads back the argmin node and its distance to select the next node to settle. The block replaces the software linear scan for the minimum unvisited node.

---
 rtl/dijkstra_min_tracker.sv | 87 ++++++++
 tb/tb_dijkstra_min_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_min_tracker.sv
// dijkstra_min_tracker: running argmin over pushed float distances; DIJKSTRA_MIN_TIE_LOW_IDX_EN picks the lowest index on equal distances
module dijkstra_min_tracker #(
  parameter int IDX_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  localparam logic [1:0] OP_CLEAR = 2'd0, OP_PUSH = 2'd1, OP_IDX = 2'd2, OP_DIST = 2'd3;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  state_t st, st_nx;
  logic [1:0] op;
  logic [IDX_W-1:0] idx, min_idx;
  logic [31:0] cand, min_dist, res_nx;
  logic [15:0] push_cnt;
  logic have_min, vld, acc, cand_ok, better, take;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else if (clk_en) st <= st_nx;
  always_comb begin
    st_nx = IDLE;
    if (st == IDLE) st_nx = start ? CMP : IDLE;
    else if (st == CMP) st_nx = DONE;
  end
  // exponent 0xFF covers both NaN and +inf once the sign is known clear
  assign cand_ok = !cand[31] && cand[30:23] != 8'hFF;
`ifdef DIJKSTRA_MIN_TIE_LOW_IDX_EN
  assign better = cand[30:0] < min_dist[30:0] || (cand[30:0] == min_dist[30:0] && idx < min_idx);
`else
  assign better = cand[30:0] < min_dist[30:0];
`endif
  assign take = cand_ok && (!have_min || better);
  always_comb
    res_nx = op == OP_PUSH ? {31'd0, acc} :
             op == OP_IDX  ? (have_min ? 32'(min_idx) : 32'hFFFF_FFFF) :
             op == OP_DIST ? min_dist : 32'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done     <= 1'b0;
      result   <= 32'd0;
      op       <= OP_CLEAR;
      idx      <= '0;
      cand     <= 32'd0;
      vld      <= 1'b0;
      acc      <= 1'b0;
      min_dist <= POS_INF;
      min_idx  <= '1;
      have_min <= 1'b0;
      push_cnt <= 16'd0;
    end else if (clk_en) begin
      if (st == IDLE) begin
        done   <= 1'b0;
        result <= 32'd0;
        if (start) begin
          op   <= n;
          idx  <= dataa[IDX_W-1:0];
          cand <= datab;
        end
      end else if (st == CMP) begin
        vld <= op == OP_PUSH && cand_ok;
        acc <= op == OP_PUSH && take;
      end else begin
        done   <= 1'b1;
        result <= res_nx;
        if (op == OP_CLEAR) begin
          min_dist <= POS_INF;
          min_idx  <= '1;
          have_min <= 1'b0;
          push_cnt <= 16'd0;
        end else begin
          if (vld && push_cnt != 16'hFFFF) push_cnt <= push_cnt + 16'd1;
          if (acc) begin
            min_dist <= cand;
            min_idx  <= idx;
            have_min <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_dijkstra_min_tracker.sv
// tb_dijkstra_min_tracker: randomized and directed checks against a frontier-list reference model
module tb_dijkstra_min_tracker;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, start = 1'b0;
  logic [1:0] n = 2'd0;
  logic [31:0] dataa = 32'd0, datab = 32'd0, result;
  logic done;
  int tests = 0, fails = 0;
  typedef struct { logic [31:0] i; logic [31:0] d; } ent_t;
  ent_t fr[$];

  dijkstra_min_tracker dut (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .result(result));

  always #5 clk = ~clk;

  function automatic bit is_valid(input logic [31:0] d);
    return d[31] == 1'b0 && !(d[30:23] == 8'hFF);
  endfunction

  // position in the frontier list of the current minimum, -1 if empty
  function automatic int best_pos();
    int p = -1;
    foreach (fr[k]) begin
      if (p < 0) p = k;
      else if (fr[k].d[30:0] < fr[p].d[30:0]) p = k;
`ifdef DIJKSTRA_MIN_TIE_LOW_IDX_EN
      else if (fr[k].d[30:0] == fr[p].d[30:0] && fr[k].i < fr[p].i) p = k;
`endif
    end
    return p;
  endfunction

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int p;
    ent_t e;
    if (op == 2'd0) begin fr.delete(); return 32'd0; end
    if (op == 2'd1) begin
      if (!is_valid(b)) return 32'd0;
      e.i = a; e.d = b;
      fr.push_back(e);
      return (best_pos() == fr.size() - 1) ? 32'd1 : 32'd0;
    end
    p = best_pos();
    if (op == 2'd2) return p < 0 ? 32'hFFFF_FFFF : fr[p].i;
    return p < 0 ? 32'h7F80_0000 : fr[p].d;
  endfunction

  // issues one instruction from posedge+1, checks 3-cycle latency and single-cycle done
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output logic [31:0] r);
    int k = 0;
    start = 1'b1; n = op; dataa = a; datab = b;
    @(posedge clk); #1 start = 1'b0;
    while (!done && k < 8) begin @(posedge clk); #1 k++; end
    tests++;
    if (k != 2) begin fails++; $display("FAIL latency op=%0d got %0d want 2", op, k); end
    r = result;
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL done_pulse done=%b result=%h want 0/0", done, result);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    tests++;
    if (done !== 1'b0 || result !== 32'd0) begin
      fails++; $display("FAIL reset_out done=%b result=%h want 0/0", done, result);
    end
    fr.delete();
    do_op(2'd2, 0, 0, r);
    tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_idx got %h want ffffffff", r); end
    do_op(2'd3, 0, 0, r);
    tests++; if (r !== 32'h7F80_0000) begin fails++; $display("FAIL reset_dist got %h want 7f800000", r); end
  endtask

  task automatic test_push_basic();
    logic [31:0] r, e;
    logic [31:0] ia[5] = '{5, 9, 3, 0, 0};
    logic [31:0] da[5] = '{32'h4020_0000, 32'h3F80_0000, 32'h4000_0000, 0, 0};
    logic [1:0]  oa[5] = '{1, 1, 1, 2, 3};
    logic [31:0] xa[5] = '{1, 1, 0, 9, 32'h3F80_0000};
    for (int k = 0; k < 5; k++) begin
      e = model(oa[k], ia[k], da[k]);
      do_op(oa[k], ia[k], da[k], r);
      tests++;
      if (r !== xa[k] || r !== e) begin
        fails++; $display("FAIL basic_%0d got %h want %h", k, r, xa[k]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] r;
    logic [31:0] bad[4] = '{32'h7F80_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h8000_0000};
    do_op(2'd0, 0, 0, r); void'(model(2'd0, 0, 0));
    foreach (bad[k]) begin
      do_op(2'd1, 7, bad[k], r);
      tests++; if (r !== 32'd0) begin fails++; $display("FAIL invalid_%0d got %h want 0", k, r); end
    end
    do_op(2'd2, 0, 0, r);
    tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL invalid_idx got %h want ffffffff", r); end
  endtask

  task automatic test_tie();
    logic [31:0] r, w;
    do_op(2'd1, 8, 32'h3F00_0000, r); void'(model(2'd1, 8, 32'h3F00_0000));
    do_op(2'd1, 2, 32'h3F00_0000, r); void'(model(2'd1, 2, 32'h3F00_0000));
`ifdef DIJKSTRA_MIN_TIE_LOW_IDX_EN
    w = 1;
`else
    w = 0;
`endif
    tests++; if (r !== w) begin fails++; $display("FAIL tie_push got %h want %h", r, w); end
    do_op(2'd2, 0, 0, r);
    w = (w == 1) ? 32'd2 : 32'd8;
    tests++; if (r !== w) begin fails++; $display("FAIL tie_idx got %h want %h", r, w); end
  endtask

  task automatic test_clk_en();
    logic [31:0] r;
    int k = 0;
    do_op(2'd0, 0, 0, r); void'(model(2'd0, 0, 0));
    start = 1'b1; n = 2'd1; dataa = 4; datab = 32'h3F80_0000;
    @(posedge clk); #1 start = 1'b0; clk_en = 1'b0; k = 0;
    repeat (4) begin
      start = ~start; dataa = 11; datab = 32'h0000_0001;
      @(posedge clk); #1 k++;
    end
    clk_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; k++;
    while (!done && k < 12) begin @(posedge clk); #1 k++; end
    tests++; if (k != 6) begin fails++; $display("FAIL clk_en_latency got %0d want 6", k); end
    tests++; if (result !== 32'd1) begin fails++; $display("FAIL clk_en_result got %h want 1", result); end
    void'(model(2'd1, 4, 32'h3F80_0000));
    k = 0;
    repeat (4) begin @(posedge clk); #1 if (done) k++; end
    tests++; if (k != 0) begin fails++; $display("FAIL clk_en_spurious got %0d dones want 0", k); end
    do_op(2'd2, 0, 0, r);
    tests++; if (r !== 32'd4) begin fails++; $display("FAIL clk_en_idx got %h want 4", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int k = 0;
    start = 1'b1; n = 2'd1; dataa = 1; datab = 32'h0000_0000;
    @(posedge clk); #1 start = 1'b0; reset = 1'b1;
    #1 tests++;
    if (done !== 1'b0 || result !== 32'd0) begin fails++; $display("FAIL mid_reset_out done=%b result=%h", done, result); end
    @(posedge clk); #1 reset = 1'b0;
    fr.delete();
    repeat (4) begin @(posedge clk); #1 if (done) k++; end
    tests++; if (k != 0) begin fails++; $display("FAIL mid_reset_done got %0d want 0", k); end
    do_op(2'd2, 0, 0, r);
    tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mid_reset_idx got %h want ffffffff", r); end
    do_op(2'd1, 6, 32'h4000_0000, r); do_op(2'd1, 3, 32'h3E00_0000, r);
    do_op(2'd0, 0, 0, r);
    tests++; if (r !== 32'd0) begin fails++; $display("FAIL clear_result got %h want 0", r); end
    do_op(2'd2, 0, 0, r);
    tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL clear_idx got %h want ffffffff", r); end
    do_op(2'd3, 0, 0, r);
    tests++; if (r !== 32'h7F80_0000) begin fails++; $display("FAIL clear_dist got %h want 7f800000", r); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    start = 1'b1; n = 2'd1; dataa = 12; datab = 32'h0000_0002;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (done !== 1'b1 || result !== 32'd1) begin fails++; $display("FAIL b2b_first done=%b result=%h want 1/1", done, result); end
    void'(model(2'd1, 12, 32'h0000_0002));
    start = 1'b1; n = 2'd2;
    @(posedge clk); #1 start = 1'b0;
    while (!done && k < 8) begin @(posedge clk); #1 k++; end
    tests++; if (k != 2 || result !== 32'd12) begin fails++; $display("FAIL b2b_second lat=%0d result=%h want 2/0000000c", k, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] r, e, a, b;
    logic [1:0] op;
    logic [31:0] pool[9] = '{32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 32'h0000_0000,
                              32'h7F80_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h8000_0000};
    for (int t = 0; t < 150; t++) begin
      k_sel: begin
        int s = $urandom_range(0, 19);
        op = s == 0 ? 2'd0 : s < 13 ? 2'd1 : s < 16 ? 2'd2 : 2'd3;
        a = $urandom_range(0, 15);
        b = $urandom_range(0, 2) == 0 ? {1'b0, 31'($urandom_range(0, 32'h7F7F_FFFF))} : pool[$urandom_range(0, 8)];
      end
      e = model(op, a, b);
      do_op(op, a, b, r);
      tests++;
      if (r !== e) begin fails++; $display("FAIL random_%0d op=%0d a=%h b=%h got %h want %h", t, op, a, b, r, e); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_push_basic();
    test_invalid();
    test_tie();
    test_clk_en();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
